// File: rtl/lockin_pkg.sv
// Shared lock-in constants: NCO/mixer default widths, quadrant encoding,
// quarter-wave table generator and the dither LFSR step.
package lockin_pkg;

  localparam int PHASE_WIDTH_DEF    = 32;
  localparam int LUT_ADDR_WIDTH_DEF = 10;
  localparam int SIN_WIDTH_DEF      = 18;
  localparam int DATA_WIDTH_DEF     = 24;
  localparam int MIX_ACC_WIDTH      = 48;
  localparam int MIX_OUT_WIDTH      = 32;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // x^16 + x^14 + x^13 + x^11 + 1, maximal length
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Half-bin-centred sample so every entry is strictly positive
  function automatic int quarter_sine_value(input int k, input int addr_w, input int sin_w);
    real arg;
    real amp;
    arg = 3.14159265358979323846 * (real'(k) + 0.5) / (2.0 * (2.0 ** addr_w));
    amp = (2.0 ** (sin_w - 1)) - 1.0;
    return $rtoi($floor(amp * $sin(arg) + 0.5));
  endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// Quarter-wave sine ROM with two registered read ports; applies the sign
// on the way into the output register (NCO stage 3).
module nco_quarter_lut
  import lockin_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_WIDTH_DEF,
  parameter int OUT_W  = SIN_WIDTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic [ADDR_W-1:0]        i_addr_a,
  input  logic                     i_neg_a,
  input  logic [ADDR_W-1:0]        i_addr_b,
  input  logic                     i_neg_b,
  output logic signed [OUT_W-1:0]  o_data_a,
  output logic signed [OUT_W-1:0]  o_data_b
);

  localparam int N     = 1 << ADDR_W;
  localparam int MAG_W = OUT_W - 1;

  logic [MAG_W-1:0]        w_rom [N];
  logic signed [OUT_W-1:0] w_val_a;
  logic signed [OUT_W-1:0] w_val_b;
  logic signed [OUT_W-1:0] r_data_a;
  logic signed [OUT_W-1:0] r_data_b;

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam int VAL = quarter_sine_value(k, ADDR_W, OUT_W);
    assign w_rom[k] = MAG_W'(VAL);
  end

  assign w_val_a = signed'({1'b0, w_rom[i_addr_a]});
  assign w_val_b = signed'({1'b0, w_rom[i_addr_b]});

  // Table read with sign restore; holds while not enabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data_a <= {OUT_W{1'b0}};
      r_data_b <= {OUT_W{1'b0}};
    end else if (i_en) begin
      r_data_a <= i_neg_a ? -w_val_a : w_val_a;
      r_data_b <= i_neg_b ? -w_val_b : w_val_b;
    end
  end

  assign o_data_a = r_data_a;
  assign o_data_b = r_data_b;

endmodule

// File: rtl/lockin_nco.sv
// Lock-in reference NCO: 3-stage phase -> sine/cosine pipeline with aligned
// data passthrough. Define LOCKIN_NCO_DITHER_EN to add LFSR phase dithering.
module lockin_nco
  import lockin_pkg::*;
#(
  parameter int PHASE_WIDTH    = PHASE_WIDTH_DEF,
  parameter int LUT_ADDR_WIDTH = LUT_ADDR_WIDTH_DEF,
  parameter int SIN_WIDTH      = SIN_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         load,
  input  logic [PHASE_WIDTH-1:0]       phase_inc,
  input  logic [PHASE_WIDTH-1:0]       phase_offset,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [SIN_WIDTH-1:0]  sine_out,
  output logic signed [SIN_WIDTH-1:0]  cosine_out,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         o_valid
);

  localparam int TRUNC_W      = PHASE_WIDTH - 2 - LUT_ADDR_WIDTH;
  localparam int FOLD_W       = LUT_ADDR_WIDTH + 2;
  localparam int DITHER_SHIFT = (TRUNC_W > 16) ? (TRUNC_W - 16) : 0;

  logic [PHASE_WIDTH-1:0]       r_acc;
  logic [PHASE_WIDTH-1:0]       r_inc;
  logic [PHASE_WIDTH-1:0]       w_acc_base;
  logic [PHASE_WIDTH-1:0]       w_acc_next;
  logic [PHASE_WIDTH-1:0]       w_dither;
  logic [PHASE_WIDTH-1:0]       w_phase_sum;
  logic                         w_unused_low;

  logic                         r_s1_valid;
  logic [FOLD_W-1:0]            r_s1_phase;
  logic signed [DATA_WIDTH-1:0] r_s1_data;

  quad_e                        w_quad;
  logic [LUT_ADDR_WIDTH-1:0]    w_addr;
  logic [LUT_ADDR_WIDTH-1:0]    w_addr_s;
  logic [LUT_ADDR_WIDTH-1:0]    w_addr_c;
  logic                         w_neg_s;
  logic                         w_neg_c;

  logic                         r_s2_valid;
  logic [LUT_ADDR_WIDTH-1:0]    r_s2_addr_s;
  logic [LUT_ADDR_WIDTH-1:0]    r_s2_addr_c;
  logic                         r_s2_neg_s;
  logic                         r_s2_neg_c;
  logic signed [DATA_WIDTH-1:0] r_s2_data;

  logic                         r_valid;
  logic signed [DATA_WIDTH-1:0] r_data_out;
  logic signed [SIN_WIDTH-1:0]  w_sine;
  logic signed [SIN_WIDTH-1:0]  w_cosine;

  // A coincident load makes this sample see a freshly cleared accumulator
  assign w_acc_base = load ? {PHASE_WIDTH{1'b0}} : r_acc;

  // Next accumulator value from load/start
  always_comb begin
    w_acc_next = r_acc;
    if (load) begin
      w_acc_next = start ? phase_inc : {PHASE_WIDTH{1'b0}};
    end else if (start) begin
      w_acc_next = r_acc + r_inc;
    end else begin
      w_acc_next = r_acc;
    end
  end

`ifdef LOCKIN_NCO_DITHER_EN
  logic [15:0] r_lfsr;

  // Dither source, stepped once per requested sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (start) begin
      r_lfsr <= lfsr16_next(r_lfsr);
    end
  end

  assign w_dither = {{(PHASE_WIDTH-16){1'b0}}, r_lfsr} << DITHER_SHIFT;
`else
  assign w_dither = {PHASE_WIDTH{1'b0}};
`endif

  assign w_phase_sum  = w_acc_base + phase_offset + w_dither;
  assign w_unused_low = ^w_phase_sum[TRUNC_W-1:0];

  // Accumulator and increment state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= {PHASE_WIDTH{1'b0}};
      r_inc <= {PHASE_WIDTH{1'b0}};
    end else begin
      r_acc <= w_acc_next;
      if (load) begin
        r_inc <= phase_inc;
      end
    end
  end

  // Stage 1: register truncated phase and data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_phase <= {FOLD_W{1'b0}};
      r_s1_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_s1_valid <= start;
      if (start) begin
        r_s1_phase <= w_phase_sum[PHASE_WIDTH-1 -: FOLD_W];
        r_s1_data  <= data_in;
      end
    end
  end

  assign w_quad = quad_e'(r_s1_phase[FOLD_W-1 -: 2]);
  assign w_addr = r_s1_phase[LUT_ADDR_WIDTH-1:0];

  // Quadrant fold: pick mirrored address and sign for each output
  always_comb begin
    w_addr_s = w_addr;
    w_addr_c = ~w_addr;
    w_neg_s  = 1'b0;
    w_neg_c  = 1'b0;
    case (w_quad)
      QUAD_0: begin
        w_addr_s = w_addr;  w_neg_s = 1'b0;
        w_addr_c = ~w_addr; w_neg_c = 1'b0;
      end
      QUAD_1: begin
        w_addr_s = ~w_addr; w_neg_s = 1'b0;
        w_addr_c = w_addr;  w_neg_c = 1'b1;
      end
      QUAD_2: begin
        w_addr_s = w_addr;  w_neg_s = 1'b1;
        w_addr_c = ~w_addr; w_neg_c = 1'b1;
      end
      QUAD_3: begin
        w_addr_s = ~w_addr; w_neg_s = 1'b1;
        w_addr_c = w_addr;  w_neg_c = 1'b0;
      end
      default: begin
        w_addr_s = w_addr;  w_neg_s = 1'b0;
        w_addr_c = ~w_addr; w_neg_c = 1'b0;
      end
    endcase
  end

  // Stage 2: register table addresses and signs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_addr_s <= {LUT_ADDR_WIDTH{1'b0}};
      r_s2_addr_c <= {LUT_ADDR_WIDTH{1'b0}};
      r_s2_neg_s  <= 1'b0;
      r_s2_neg_c  <= 1'b0;
      r_s2_data   <= {DATA_WIDTH{1'b0}};
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_addr_s <= w_addr_s;
        r_s2_addr_c <= w_addr_c;
        r_s2_neg_s  <= w_neg_s;
        r_s2_neg_c  <= w_neg_c;
        r_s2_data   <= r_s1_data;
      end
    end
  end

  nco_quarter_lut #(
    .ADDR_W (LUT_ADDR_WIDTH),
    .OUT_W  (SIN_WIDTH)
  ) u_lut (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_en     (r_s2_valid),
    .i_addr_a (r_s2_addr_s),
    .i_neg_a  (r_s2_neg_s),
    .i_addr_b (r_s2_addr_c),
    .i_neg_b  (r_s2_neg_c),
    .o_data_a (w_sine),
    .o_data_b (w_cosine)
  );

  // Stage 3 companions: valid strobe and aligned data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_data_out <= {DATA_WIDTH{1'b0}};
    end else begin
      r_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_data_out <= r_s2_data;
      end
    end
  end

  assign sine_out   = w_sine;
  assign cosine_out = w_cosine;
  assign data_out   = r_data_out;
  assign o_valid    = r_valid;

endmodule

// File: tb/tb_lockin_nco.sv
// Directed self-checking bench for lockin_nco (default parameters, no dither).
module tb_lockin_nco;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               load;
  logic [31:0]        phase_inc;
  logic [31:0]        phase_offset;
  logic signed [23:0] data_in;
  logic signed [17:0] sine_out;
  logic signed [17:0] cosine_out;
  logic signed [23:0] data_out;
  logic               o_valid;

  int n_cmp;
  int n_err;

  localparam longint PK = 131071;
  localparam longint LO = 101;

  lockin_nco dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .load         (load),
    .phase_inc    (phase_inc),
    .phase_offset (phase_offset),
    .data_in      (data_in),
    .sine_out     (sine_out),
    .cosine_out   (cosine_out),
    .data_out     (data_out),
    .o_valid      (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input longint s,
                            input longint c, input longint d);
    check_val({tag, ".valid"}, longint'(o_valid), longint'(v));
    check_val({tag, ".sine"},  longint'(sine_out), s);
    check_val({tag, ".cos"},   longint'(cosine_out), c);
    check_val({tag, ".data"},  longint'(data_out), d);
  endtask

  // Drive one cycle of inputs, then advance to the next falling edge
  task automatic cyc(input logic st, input logic ld, input logic [31:0] inc,
                     input logic [31:0] off, input logic signed [23:0] d);
    start        = st;
    load         = ld;
    phase_inc    = inc;
    phase_offset = off;
    data_in      = d;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 24'sd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    load  = 1'b0;
    phase_inc    = 32'h0;
    phase_offset = 32'h0;
    data_in      = 24'sd0;
    @(negedge clk);
    @(negedge clk);
    expect_out("rst_hold", 1'b0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle();
      expect_out("rst_idle", 1'b0, 0, 0, 0);
    end

    // No load after reset: inc 0, phase equals offset on every start
    cyc(1'b1, 1'b0, 32'h0, 32'h8000_0000, 24'sd11);
    cyc(1'b1, 1'b0, 32'h0, 32'h8000_0000, 24'sd12);
    idle();
    expect_out("noload0", 1'b1, -LO, -PK, 11);
    idle();
    expect_out("noload1", 1'b1, -LO, -PK, 12);

    // 90-degree steps with data alignment
    cyc(1'b0, 1'b1, 32'h4000_0000, 32'h0, 24'sd0);
    expect_out("load", 1'b0, -LO, -PK, 12);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 24'sd1000);
    check_val("lat1.valid", longint'(o_valid), 0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, -24'sd1000);
    check_val("lat2.valid", longint'(o_valid), 0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 24'sd77);
    expect_out("q0", 1'b1, LO, PK, 1000);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, -24'sd5);
    expect_out("q1", 1'b1, PK, -LO, -1000);
    idle();
    expect_out("q2", 1'b1, -LO, -PK, 77);
    idle();
    expect_out("q3", 1'b1, -PK, LO, -5);
    idle();
    expect_out("hold", 1'b0, -PK, LO, -5);

    // Offset-only phase shift
    cyc(1'b0, 1'b1, 32'h0, 32'h0, 24'sd0);
    cyc(1'b1, 1'b0, 32'h0, 32'h4000_0000, 24'sd42);
    idle();
    idle();
    expect_out("offset90", 1'b1, PK, -LO, 42);

    // Load coincident with start, then wrap-around
    cyc(1'b1, 1'b1, 32'hC000_0000, 32'h0, 24'sd1);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 24'sd2);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 24'sd3);
    expect_out("wrap0", 1'b1, LO, PK, 1);
    idle();
    expect_out("wrap1", 1'b1, -PK, LO, 2);
    idle();
    expect_out("wrap2", 1'b1, -LO, -PK, 3);
    idle();
    check_val("wrap_end.valid", longint'(o_valid), 0);

    // Reset one cycle after a start discards the sample
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 24'sd99);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    expect_out("midrst", 1'b0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle();
      expect_out("postrst", 1'b0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
